// File: rtl/rx_data_sampling.sv
// Oversampled serial-bit sampler: synchronizes rx_in, tracks the edge and bit
// position inside a frame, and majority-votes three mid-bit samples per bit.
module rx_data_sampling #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic [5:0] prescale,
  input  logic       enable,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       bit_done,
  output logic       sampled_bit,
  output logic       sample_valid
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   rx_s;
  logic                   enable_r;
  logic                   active_r;
  logic [5:0]             p_q;
  logic                   s0;
  logic                   s1;
  logic                   s2;
  logic                   rise_s;
  logic                   run_s;
  logic [5:0]             mid_s;
  logic [5:0]             last_s;

  function automatic logic [5:0] decode_prescale(input logic [5:0] p);
    logic [5:0] r;
    case (p)
      6'd8, 6'd16, 6'd32: r = p;
      default:            r = 6'd8;
    endcase
    return r;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign rx_s = sync_r[SYNC_STAGES-1];

  // Counting only runs after a genuine enable rise; enable held through reset does not count.
  always_comb begin
    rise_s   = enable & ~enable_r;
    run_s    = enable & (active_r | rise_s);
    mid_s    = {1'b0, p_q[5:1]};
    last_s   = p_q - 6'd1;
    bit_done = run_s & (edge_cnt == last_s);
  end

  // Synchronizer, prescale latch, edge/bit counters and three-point majority sampling.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r       <= {SYNC_STAGES{1'b1}};
      enable_r     <= 1'b1;
      active_r     <= 1'b0;
      p_q          <= 6'd8;
      edge_cnt     <= 6'd0;
      bit_cnt      <= 4'd0;
      s0           <= 1'b0;
      s1           <= 1'b0;
      s2           <= 1'b0;
      sampled_bit  <= 1'b1;
      sample_valid <= 1'b0;
    end else begin
      sync_r       <= {sync_r[SYNC_STAGES-2:0], rx_in};
      enable_r     <= enable;
      sample_valid <= 1'b0;
      if (rise_s) begin
        p_q <= decode_prescale(prescale);
      end else begin
        p_q <= p_q;
      end
      if (!run_s) begin
        active_r <= 1'b0;
        edge_cnt <= 6'd0;
        bit_cnt  <= 4'd0;
        s0       <= 1'b0;
        s1       <= 1'b0;
        s2       <= 1'b0;
      end else begin
        active_r <= 1'b1;
        if (bit_done) begin
          edge_cnt <= 6'd0;
          if (bit_cnt == 4'(FRAME_BITS - 1)) begin
            bit_cnt <= 4'd0;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end else begin
          edge_cnt <= edge_cnt + 6'd1;
        end
        if (edge_cnt == mid_s - 6'd1) s0 <= rx_s;
        if (edge_cnt == mid_s)        s1 <= rx_s;
        if (edge_cnt == mid_s + 6'd1) s2 <= rx_s;
        if (edge_cnt == mid_s + 6'd2) begin
          sampled_bit  <= majority3(s0, s1, s2);
          sample_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_data_sampling.sv
// Directed bench for rx_data_sampling: a vector table for the basic 8x case
// followed by hand-written multi-cycle sequences.
module tb_rx_data_sampling;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       enable = 1'b0;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       bit_done;
  logic       sampled_bit;
  logic       sample_valid;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       en;
    logic [5:0] p;
    logic       rx;
    int         e;
    int         b;
    int         d;
    int         v;
    int         s;
  } vec_t;

  vec_t tbl[19];
  logic [10:0] frame;

  rx_data_sampling #(.SYNC_STAGES(2), .FRAME_BITS(11)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale), .enable(enable),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .bit_done(bit_done),
    .sampled_bit(sampled_bit), .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One cycle: inputs applied just after the edge, outputs observed shortly after.
  task automatic cyc(input logic r, input logic en, input logic [5:0] p, input logic rxi);
    @(posedge clk);
    #1;
    rst = r; enable = en; prescale = p; rx_in = rxi;
    #1;
  endtask

  task automatic chk_all(input string tag, input int e, input int b, input int d, input int v, input int s);
    chk({tag, " edge_cnt"}, int'(edge_cnt), e);
    chk({tag, " bit_cnt"}, int'(bit_cnt), b);
    chk({tag, " bit_done"}, int'(bit_done), d);
    chk({tag, " sample_valid"}, int'(sample_valid), v);
    chk({tag, " sampled_bit"}, int'(sampled_bit), s);
  endtask

  initial begin
    for (int i = 0; i < 17; i++) begin
      tbl[i] = '{1'b1, 6'd8, 1'b0, i % 8, i / 8, (i % 8 == 7) ? 1 : 0,
                 (i % 8 == 7) ? 1 : 0, (i >= 7) ? 0 : 1};
    end
    tbl[17] = '{1'b0, 6'd8, 1'b0, 1, 2, 0, 0, 0};
    tbl[18] = '{1'b0, 6'd8, 1'b0, 0, 0, 0, 0, 0};
    frame = 11'b11010101010;  // bit i of the frame is frame[i]

    // Reset values
    cyc(1'b1, 1'b0, 6'd8, 1'b1);
    cyc(1'b1, 1'b0, 6'd8, 1'b1);
    chk_all("reset", 0, 0, 0, 0, 1);
    cyc(1'b0, 1'b0, 6'd8, 1'b0);
    cyc(1'b0, 1'b0, 6'd8, 1'b0);

    // Table: prescale 8, rx low, then enable drop
    for (int i = 0; i < 19; i++) begin
      cyc(1'b0, tbl[i].en, tbl[i].p, tbl[i].rx);
      chk_all($sformatf("vec%0d", i), tbl[i].e, tbl[i].b, tbl[i].d, tbl[i].v, tbl[i].s);
    end

    // Full 11-bit frame at prescale 8, bit_cnt wraps after bit 10
    for (int i = 0; i < 90; i++) begin
      cyc(1'b0, 1'b1, 6'd8, (i < 88) ? frame[i / 8] : 1'b1);
      chk($sformatf("frame%0d edge_cnt", i), int'(edge_cnt), i % 8);
      chk($sformatf("frame%0d bit_cnt", i), int'(bit_cnt), (i / 8) % 11);
      chk($sformatf("frame%0d sample_valid", i), int'(sample_valid), (i % 8 == 7) ? 1 : 0);
      if (i % 8 == 7 && i < 88)
        chk($sformatf("frame%0d sampled_bit", i), int'(sampled_bit), int'(frame[i / 8]));
    end

    // Prescale 16 glitch voting: single glitch rejected, double glitch accepted
    cyc(1'b0, 1'b0, 6'd16, 1'b0);
    cyc(1'b0, 1'b0, 6'd16, 1'b0);
    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, 1'b1, 6'd16, (i == 6 || i == 21 || i == 22) ? 1'b1 : 1'b0);
      chk($sformatf("glitch%0d edge_cnt", i), int'(edge_cnt), i % 16);
      chk($sformatf("glitch%0d bit_done", i), int'(bit_done), (i % 16 == 15) ? 1 : 0);
      chk($sformatf("glitch%0d sample_valid", i), int'(sample_valid), (i % 16 == 11) ? 1 : 0);
      if (i == 11) chk("glitch single sampled_bit", int'(sampled_bit), 0);
      if (i == 27) chk("glitch double sampled_bit", int'(sampled_bit), 1);
    end

    // Prescale change mid-frame is ignored until the next enable rise
    cyc(1'b0, 1'b0, 6'd8, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b1, (i < 3) ? 6'd8 : 6'd32, 1'b1);
      chk($sformatf("p8hold%0d edge_cnt", i), int'(edge_cnt), i % 8);
      chk($sformatf("p8hold%0d bit_done", i), int'(bit_done), (i % 8 == 7) ? 1 : 0);
    end
    cyc(1'b0, 1'b0, 6'd32, 1'b1);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, 1'b1, 6'd32, 1'b1);
      chk($sformatf("p32_%0d edge_cnt", i), int'(edge_cnt), i % 32);
      chk($sformatf("p32_%0d bit_done", i), int'(bit_done), (i % 32 == 31) ? 1 : 0);
      if (i == 19) chk("p32 sample_valid at 19", int'(sample_valid), 1);
      if (i == 18) chk("p32 sample_valid at 18", int'(sample_valid), 0);
    end

    // Enable drops at edge 3: no sample, counters clear, sampled_bit holds 1
    cyc(1'b0, 1'b0, 6'd8, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 6'd8, 1'b0);
    cyc(1'b0, 1'b0, 6'd8, 1'b0);
    chk_all("drop@3", 3, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b0, 6'd8, 1'b0);
      chk_all($sformatf("after_drop%0d", i), 0, 0, 0, 0, 1);
    end

    // Enable drops on the last edge of a bit: no bit_done, bit_cnt clears
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 6'd8, 1'b0);
    cyc(1'b0, 1'b0, 6'd8, 1'b0);
    chk("drop@7 edge_cnt", int'(edge_cnt), 7);
    chk("drop@7 bit_done", int'(bit_done), 0);
    cyc(1'b0, 1'b0, 6'd8, 1'b0);
    chk("drop@7 next bit_cnt", int'(bit_cnt), 0);
    chk("drop@7 next edge_cnt", int'(edge_cnt), 0);

    // Reset mid-frame with sampled_bit low, then illegal prescale 20 -> period 8
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 6'd8, 1'b0);
    chk("pre-reset sampled_bit", int'(sampled_bit), 0);
    chk("pre-reset bit_cnt", int'(bit_cnt), 1);
    cyc(1'b1, 1'b1, 6'd8, 1'b0);
    cyc(1'b0, 1'b1, 6'd8, 1'b0);
    chk_all("midreset", 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 6'd8, 1'b0);
      chk($sformatf("postreset_hold%0d edge_cnt", i), int'(edge_cnt), 0);
    end
    cyc(1'b0, 1'b0, 6'd20, 1'b1);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 6'd20, 1'b1);
      chk($sformatf("p20_%0d edge_cnt", i), int'(edge_cnt), i % 8);
      chk($sformatf("p20_%0d bit_done", i), int'(bit_done), (i % 8 == 7) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_data_sampling.md
RX_DATA_SAMPLING -- requirements
Module: rx_data_sampling

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flops in the rx_in synchronizer chain (legal 2-3).
REQ-002 Parameter FRAME_BITS, default 11: bits per frame (start + 8 data + parity + stop); sets the bit_cnt wrap point.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high, ports as below.
REQ-004 clk  input  1  Block clock (oversampling clock); all state updates on its rising edge.
REQ-005 rst  input  1  Synchronous active-high reset.
REQ-006 rx_in  input  1  Asynchronous serial line; idle high.
REQ-007 prescale  input  6  Oversampling ratio; legal values 8, 16, 32.
REQ-008 enable  input  1  From RX FSM; high while a frame is being received.
REQ-009 edge_cnt  output  6  Current oversample edge index within the bit, 0..prescale-1.
REQ-010 bit_cnt  output  4  Index of the bit in progress within the frame, 0..FRAME_BITS-1.
REQ-011 bit_done  output  1  One-cycle pulse on the last edge of each bit.
REQ-012 sampled_bit  output  1  Majority-voted bit value; feeds the stop/parity/start check stages; held between updates.
REQ-013 sample_valid  output  1  One-cycle pulse when sampled_bit has just been updated.

Function
REQ-014 rx_in SHALL pass through a SYNC_STAGES-deep flop chain (reset value 1); all sampling uses the chain output rx_s.
REQ-015 The prescale value SHALL be latched into an internal register (p_q) on the cycle enable rises 0->1; later prescale changes SHALL have no effect until the next rise.
REQ-016 A latched value other than 8, 16 or 32 SHALL be treated as 8.
REQ-017 mid SHALL equal p_q/2 (right shift by one).
REQ-018 While enable=1, edge_cnt SHALL increment by 1 per cycle and wrap from p_q-1 to 0.
REQ-019 edge_cnt SHALL be 0 in the first enabled cycle.
REQ-020 bit_done SHALL be high exactly in cycles where enable=1 and edge_cnt==p_q-1.
REQ-021 bit_cnt SHALL increment on each bit_done and wrap from FRAME_BITS-1 to 0.
REQ-022 The block SHALL capture rx_s into s0, s1 and s2 in the cycles where edge_cnt equals mid-1, mid and mid+1 respectively.
REQ-023 In the cycle edge_cnt==mid+2, the block SHALL register the majority of s0, s1 and s2 into sampled_bit and set sample_valid.
REQ-024 The new sampled_bit SHALL first be visible when edge_cnt==mid+3, with sample_valid high for that one cycle only.
REQ-025 Exactly one sample_valid SHALL occur per bit period.
REQ-026 When enable=0, edge_cnt, bit_cnt and s0..s2 SHALL clear to 0 on the next edge; bit_done and sample_valid SHALL be 0; sampled_bit SHALL hold its last value.
REQ-027 If enable falls mid-bit before edge_cnt==mid+2, no sample_valid SHALL be produced for that partial bit.
REQ-028 If enable falls and rises on consecutive cycles, counting SHALL restart from edge_cnt=0 and bit_cnt=0 with prescale re-latched.
REQ-029 If a bit_done cycle coincides with enable falling, bit_cnt SHALL still clear (clear has priority over increment).

Reset
REQ-030 On rst=1 at a clock edge, the block SHALL set edge_cnt=0, bit_cnt=0, bit_done=0, sample_valid=0, sampled_bit=1, s0..s2=0, synchronizer flops=1 and p_q=8.
REQ-031 Reset SHALL take priority over enable, including mid-frame.
REQ-032 After rst deasserts, the block SHALL wait for a fresh enable rise before counting.

Verification
REQ-033 prescale=8, enable held, rx_in=0 steady -> edge_cnt sequence 0..7 repeating; bit_done at edge_cnt 7; sampled_bit=0 with sample_valid at edge_cnt 7 of each bit.
REQ-034 prescale=16, rx_s glitches to 1 only at edge_cnt 8 of a 0 bit -> sampled_bit=0 (2-of-3 vote); glitch at edges 7 and 8 -> sampled_bit=1 at edge_cnt 11.
REQ-035 prescale=8 frame 0,1,0,1,0,1,0,1,0,1,1 over 11 bits -> 11 sample_valid pulses carrying those values; bit_cnt goes 0..10 then wraps to 0.
REQ-036 prescale changes from 8 to 32 mid-frame -> period stays 8 until enable drops and rises again, then 32.
REQ-037 enable drops at edge_cnt=3 of a bit -> no sample_valid; next cycle edge_cnt=0 and bit_cnt=0; sampled_bit unchanged.
REQ-038 rst asserted mid-frame with sampled_bit=0 -> next edge all outputs at reset values (sampled_bit=1); prescale=20 latched later -> period 8.
